fetch_queue: RTL and testbench

Parametrised instruction-fetch front end: owns the fetch program counter, issues one read per cycle to a synchronous instruction memory, and buffers the returned words with their PCs in a DEPTH-entry FIFO. Decode consumes them through a valid/ready handshake. This decouples fetch from decode stalls and branch redirects. It replaces the single-register PC plus memory fetch stage, adding a prefetch buffer, a configurable reset vector and squash-on-redirect.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one read per cycle to a
// synchronous instruction memory and buffers {PC, inst} pairs for decode.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_FQ_redirect,
    input  logic [XLEN-1:0] i_FQ_redirect_PC,
    output logic            o_FQ_imem_en,
    output logic [XLEN-1:0] o_FQ_imem_addr,
    input  logic [XLEN-1:0] i_FQ_imem_data,
    output logic            o_FQ_valid,
    input  logic            i_FQ_ready,
    output logic [XLEN-1:0] o_FQ_inst,
    output logic [XLEN-1:0] o_FQ_PC,
    output logic [XLEN-1:0] o_FQ_PC_PLUS
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            inflight_q, inflight_d;
    logic            squash_q, squash_d;
    entry_t          fifo_q [DEPTH];

    logic            pop;
    logic            push;
    logic            wr_en;
    logic            issue;
    logic [CW-1:0]   occupancy;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_FQ_redirect_PC[1:0];

    // Issue only when the queue can absorb every outstanding response.
    always_comb begin
        pop        = (count_q != '0) & i_FQ_ready;
        push       = inflight_q & ~squash_q;
        occupancy  = count_q + CW'(inflight_q) - CW'(pop);
        issue      = (occupancy < CW'(DEPTH)) & ~rst & ~i_FQ_redirect;

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = issue;
        squash_d   = 1'b0;
        wr_en      = 1'b0;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            req_pc_d   = fetch_pc_q;
        end

        // Redirect flushes everything and drops any same-cycle pop or response.
        if (i_FQ_redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            squash_d   = inflight_q;
            fetch_pc_d = {i_FQ_redirect_PC[XLEN-1:2], 2'b00};
        end else begin
            wr_en = push;
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until first fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (wr_en) begin
            fifo_q[wr_ptr_q] <= '{pc: req_pc_q, inst: i_FQ_imem_data};
        end
    end

    assign o_FQ_imem_en   = issue;
    assign o_FQ_imem_addr = fetch_pc_q;
    assign o_FQ_valid     = (count_q != '0);
    assign o_FQ_inst      = fifo_q[rd_ptr_q].inst;
    assign o_FQ_PC        = fifo_q[rd_ptr_q].pc;
    assign o_FQ_PC_PLUS   = fifo_q[rd_ptr_q].pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; memory returns inst = addr + 0x1000_0000.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        valid;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus;

    int n_checks;
    int n_errors;

    localparam logic [31:0] INST_OFS = 32'h1000_0000;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_FQ_redirect    (redirect),
        .i_FQ_redirect_PC (redirect_pc),
        .o_FQ_imem_en     (imem_en),
        .o_FQ_imem_addr   (imem_addr),
        .i_FQ_imem_data   (imem_data),
        .o_FQ_valid       (valid),
        .i_FQ_ready       (ready),
        .o_FQ_inst        (inst),
        .o_FQ_PC          (pc),
        .o_FQ_PC_PLUS     (pc_plus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data valid one cycle after the request.
    always @(posedge clk) begin
        if (imem_en) imem_data <= imem_addr + INST_OFS;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_inst"}, inst, exp_pc + INST_OFS);
        check({tag, "_pcplus"}, pc_plus, exp_pc + 32'd4);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        imem_data   = '0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        ready       = 1'b1;
        tick();
        tick();
        #1;
        check("rst_en", 32'(imem_en), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pcplus", pc_plus, 32'h4);

        // Startup and streaming
        rst = 1'b0;
        #1;
        check("t0_en", 32'(imem_en), 32'd1);
        check("t0_addr", imem_addr, 32'h0);
        check("t0_valid", 32'(valid), 32'd0);
        tick(); #1;
        check("t1_valid", 32'(valid), 32'd0);
        check("t1_addr", imem_addr, 32'h4);
        tick(); #1;
        check_head("t2", 32'h0);
        for (int k = 1; k <= 16; k++) begin
            tick(); #1;
            check_head("stream", 32'(4 * k));
            check("stream_en", 32'(imem_en), 32'd1);
        end

        // Reset mid-stream with head at 0x40
        rst = 1'b1;
        #1;
        check("mrst_en", 32'(imem_en), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mrst_valid", 32'(valid), 32'd0);
        check("mrst_pc", pc, 32'h0);
        check("mrst_inst", inst, 32'h0);
        check("mrst_pcplus", pc_plus, 32'h4);
        check("mrst_addr", imem_addr, 32'h0);
        check("mrst_en_t0", 32'(imem_en), 32'd1);
        tick(); #1;
        check("mrst_valid_t1", 32'(valid), 32'd0);
        tick(); #1;
        check_head("mrst_t2", 32'h0);

        // Wrap-around redirect; low bits of the target are ignored
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        #1;
        check("wrap_r_en", 32'(imem_en), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("wrap_r1_valid", 32'(valid), 32'd0);
        check("wrap_r1_en", 32'(imem_en), 32'd1);
        check("wrap_r1_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); #1;
        check("wrap_r2_valid", 32'(valid), 32'd0);
        check("wrap_r2_addr", imem_addr, 32'h0);
        tick(); #1;
        check("wrap_r3_valid", 32'(valid), 32'd1);
        check("wrap_r3_pc", pc, 32'hFFFF_FFFC);
        check("wrap_r3_inst", inst, 32'h0FFF_FFFC);
        check("wrap_r3_pcplus", pc_plus, 32'h0);
        tick(); #1;
        check_head("wrap_r4", 32'h0);

        // Redirect with a response in flight and a pop in the same cycle
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        check("rdp_r_en", 32'(imem_en), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("rdp_r1_valid", 32'(valid), 32'd0);
        check("rdp_r1_addr", imem_addr, 32'h200);
        check("rdp_r1_en", 32'(imem_en), 32'd1);
        tick(); #1;
        check("rdp_r2_valid", 32'(valid), 32'd0);
        tick(); #1;
        check_head("rdp_r3", 32'h200);
        tick(); #1;
        check_head("rdp_r4", 32'h204);

        // Full stall: exactly four requests then issue stops
        rst   = 1'b1;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("stall_en", 32'(imem_en), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) check("stall_addr", imem_addr, 32'(4 * i));
            tick(); #1;
        end
        check("stall_full_en", 32'(imem_en), 32'd0);
        check_head("stall_full", 32'h0);
        ready = 1'b1;
        #1;
        check("rel_en", 32'(imem_en), 32'd1);
        check("rel_addr", imem_addr, 32'h10);
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            check_head("rel", 32'(4 * k));
        end

        // Redirect with a full queue
        rst   = 1'b1;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check("rfull_r_en", 32'(imem_en), 32'd0);
        check("rfull_r_valid", 32'(valid), 32'd1);
        tick();
        redirect = 1'b0;
        #1;
        check("rfull_r1_valid", 32'(valid), 32'd0);
        check("rfull_r1_en", 32'(imem_en), 32'd1);
        check("rfull_r1_addr", imem_addr, 32'h100);
        tick(); #1;
        check("rfull_r2_valid", 32'(valid), 32'd0);
        check("rfull_r2_addr", imem_addr, 32'h104);
        tick();
        ready = 1'b1;
        #1;
        check_head("rfull_r3", 32'h100);
        tick(); #1;
        check_head("rfull_r4", 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
